// File: rtl/sprite_shifter_bank_if.sv
// Load/render control bus into the sprite shifter bank and its registered pixel outputs.
interface sprite_shifter_bank_if #(
   parameter int SLOT_W = 3,
   parameter int X_W    = 8,
   parameter int PAT_W  = 8
);
   logic              line_clr;
   logic              ld_valid;
   logic [SLOT_W-1:0] ld_slot;
   logic [X_W-1:0]    ld_x;
   logic [3:0]        ld_attr;
   logic              ld_sprite0;
   logic [PAT_W-1:0]  ld_pat_lo;
   logic [PAT_W-1:0]  ld_pat_hi;
   logic              render_en;
   logic              next_pixel;
   logic [3:0]        spr_pixel;
   logic              spr_priority;
   logic              spr0_opaque;

   modport master (
      output line_clr, ld_valid, ld_slot, ld_x, ld_attr, ld_sprite0,
             ld_pat_lo, ld_pat_hi, render_en, next_pixel,
      input  spr_pixel, spr_priority, spr0_opaque
   );

   modport slave (
      input  line_clr, ld_valid, ld_slot, ld_x, ld_attr, ld_sprite0,
             ld_pat_lo, ld_pat_hi, render_en, next_pixel,
      output spr_pixel, spr_priority, spr0_opaque
   );
endinterface

// File: rtl/sprite_shifter_bank.sv
// Per-scanline sprite slots: X down-counters and 2-plane shifters with lowest-index priority.
// Outputs are registered, 1 cycle after the advance strobe; they hold between strobes.
module sprite_shifter_bank #(
   parameter int NUM_SPRITES = 8,
   parameter int SLOT_W      = 3,
   parameter int X_W         = 8,
   parameter int PAT_W       = 8
) (
   input logic                clk,
   input logic                rst,
   sprite_shifter_bank_if.slave bus
);
   logic             valid   [NUM_SPRITES];
   logic [X_W-1:0]   x_cnt   [NUM_SPRITES];
   logic [PAT_W-1:0] pat_lo  [NUM_SPRITES];
   logic [PAT_W-1:0] pat_hi  [NUM_SPRITES];
   logic [1:0]       pal     [NUM_SPRITES];
   logic             behind  [NUM_SPRITES];
   logic             is_spr0 [NUM_SPRITES];

   logic             opaque  [NUM_SPRITES];
   logic [3:0]       win_pixel;
   logic             win_priority;
   logic             any_spr0;
   logic             advance;

   logic [3:0]       pixel_q;
   logic             priority_q;
   logic             spr0_q;

   function automatic logic [PAT_W-1:0] bit_rev(input logic [PAT_W-1:0] v);
      logic [PAT_W-1:0] r;
      for (int b = 0; b < PAT_W; b++) begin
         r[b] = v[PAT_W-1-b];
      end
      return r;
   endfunction

   assign advance = bus.render_en && bus.next_pixel;

   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         opaque[i] = valid[i] && (x_cnt[i] == '0) &&
                     (pat_hi[i][PAT_W-1] || pat_lo[i][PAT_W-1]);
      end
   end

   // Walk from the highest slot down so the lowest opaque index is the last writer.
   always_comb begin
      win_pixel    = 4'b0000;
      win_priority = 1'b0;
      any_spr0     = 1'b0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (opaque[i]) begin
            win_pixel    = {pal[i], pat_hi[i][PAT_W-1], pat_lo[i][PAT_W-1]};
            win_priority = behind[i];
         end
         if (opaque[i] && is_spr0[i]) begin
            any_spr0 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            valid[i]   <= 1'b0;
            x_cnt[i]   <= '0;
            pat_lo[i]  <= '0;
            pat_hi[i]  <= '0;
            pal[i]     <= 2'b00;
            behind[i]  <= 1'b0;
            is_spr0[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (bus.ld_valid && (bus.ld_slot == SLOT_W'(i))) begin
               // Load takes precedence over line_clr and over any advance of this slot.
               valid[i]   <= 1'b1;
               x_cnt[i]   <= bus.ld_x;
               pat_lo[i]  <= bus.ld_attr[3] ? bit_rev(bus.ld_pat_lo) : bus.ld_pat_lo;
               pat_hi[i]  <= bus.ld_attr[3] ? bit_rev(bus.ld_pat_hi) : bus.ld_pat_hi;
               pal[i]     <= bus.ld_attr[1:0];
               behind[i]  <= bus.ld_attr[2];
               is_spr0[i] <= bus.ld_sprite0;
            end else begin
               if (bus.line_clr) begin
                  valid[i] <= 1'b0;
               end
               if (advance && valid[i]) begin
                  if (x_cnt[i] != '0) begin
                     x_cnt[i] <= x_cnt[i] - X_W'(1);
                  end else begin
                     pat_lo[i] <= pat_lo[i] << 1;
                     pat_hi[i] <= pat_hi[i] << 1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !bus.render_en) begin
         pixel_q    <= 4'b0000;
         priority_q <= 1'b0;
         spr0_q     <= 1'b0;
      end else if (advance) begin
         pixel_q    <= win_pixel;
         priority_q <= win_priority;
         spr0_q     <= any_spr0;
      end
   end

   assign bus.spr_pixel    = pixel_q;
   assign bus.spr_priority = priority_q;
   assign bus.spr0_opaque  = spr0_q;
endmodule

// File: tb/tb_sprite_shifter_bank.sv
// Directed bench for sprite_shifter_bank with an expected-output queue per strobe.
module tb_sprite_shifter_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct packed {
      logic [3:0] pix;
      logic       pri;
      logic       s0;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   sprite_shifter_bank_if #(.SLOT_W(3), .X_W(8), .PAT_W(8)) bus ();

   sprite_shifter_bank #(
      .NUM_SPRITES(8), .SLOT_W(3), .X_W(8), .PAT_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input exp_t e);
      chk({tag, ".pix"}, bus.spr_pixel, e.pix);
      chk({tag, ".pri"}, {3'b000, bus.spr_priority}, {3'b000, e.pri});
      chk({tag, ".s0"},  {3'b000, bus.spr0_opaque},  {3'b000, e.s0});
   endtask

   task automatic load(input logic [2:0] slot, input logic [7:0] x, input logic [3:0] attr,
                       input logic s0, input logic [7:0] lo, input logic [7:0] hi,
                       input logic clr);
      bus.line_clr   = clr;
      bus.ld_valid   = 1'b1;
      bus.ld_slot    = slot;
      bus.ld_x       = x;
      bus.ld_attr    = attr;
      bus.ld_sprite0 = s0;
      bus.ld_pat_lo  = lo;
      bus.ld_pat_hi  = hi;
   endtask

   task automatic release_load();
      bus.line_clr = 1'b0;
      bus.ld_valid = 1'b0;
   endtask

   // One pixel strobe; any load already set up is applied in the same cycle.
   task automatic strobe(input string tag, input logic [3:0] pix, input logic pri,
                         input logic s0);
      exp_t e;
      e.pix = pix;
      e.pri = pri;
      e.s0  = s0;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      bus.next_pixel = 1'b1;
      tick();
      bus.next_pixel = 1'b0;
      release_load();
      chk_outputs(tag_q.pop_front(), exp_q.pop_front());
   endtask

   initial begin
      exp_t zero_e;
      zero_e = '0;
      bus.line_clr   = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.ld_slot    = '0;
      bus.ld_x       = '0;
      bus.ld_attr    = '0;
      bus.ld_sprite0 = 1'b0;
      bus.ld_pat_lo  = '0;
      bus.ld_pat_hi  = '0;
      bus.render_en  = 1'b0;
      bus.next_pixel = 1'b0;

      rst = 1'b1;
      tick();
      tick();
      chk_outputs("reset", zero_e);
      rst = 1'b0;
      bus.render_en = 1'b1;
      tick();

      for (int i = 0; i < 20; i++) strobe("empty", 4'b0000, 1'b0, 1'b0);

      // x=2, lo all ones, palette 01
      load(3'd0, 8'd2, 4'b0001, 1'b0, 8'hFF, 8'h00, 1'b1);
      tick();
      release_load();
      strobe("x2_delay0", 4'b0000, 1'b0, 1'b0);
      strobe("x2_delay1", 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) strobe("x2_vis", 4'b0101, 1'b0, 1'b0);
      strobe("x2_done0", 4'b0000, 1'b0, 1'b0);
      strobe("x2_done1", 4'b0000, 1'b0, 1'b0);

      // hflip: LSB of the loaded row appears first
      load(3'd0, 8'd0, 4'b1000, 1'b0, 8'h01, 8'h00, 1'b1);
      tick();
      release_load();
      strobe("hflip_first", 4'b0001, 1'b0, 1'b0);
      strobe("hflip_after0", 4'b0000, 1'b0, 1'b0);
      strobe("hflip_after1", 4'b0000, 1'b0, 1'b0);

      // slot1 alternating opaque/transparent over always-opaque slot3
      load(3'd1, 8'd0, 4'b0010, 1'b0, 8'b1010_0000, 8'h00, 1'b1);
      tick();
      load(3'd3, 8'd0, 4'b0111, 1'b0, 8'hFF, 8'hFF, 1'b0);
      tick();
      release_load();
      strobe("prio_s1_a", 4'b1001, 1'b0, 1'b0);
      strobe("prio_s3_a", 4'b1111, 1'b1, 1'b0);
      strobe("prio_s1_b", 4'b1001, 1'b0, 1'b0);
      strobe("prio_s3_b", 4'b1111, 1'b1, 1'b0);

      // sprite 0 in slot2 hidden under slot0
      load(3'd0, 8'd0, 4'b0000, 1'b0, 8'hFF, 8'hFF, 1'b1);
      tick();
      load(3'd2, 8'd0, 4'b0010, 1'b1, 8'hFF, 8'h00, 1'b0);
      tick();
      release_load();
      strobe("spr0_hidden", 4'b0011, 1'b0, 1'b1);

      // line_clr with a load to slot4 in the same cycle
      load(3'd4, 8'd1, 4'b0001, 1'b0, 8'hFF, 8'h00, 1'b1);
      tick();
      release_load();
      strobe("clr_ld_delay", 4'b0000, 1'b0, 1'b0);
      strobe("clr_ld_vis", 4'b0101, 1'b0, 1'b0);
      // reload slot4 during a strobe: output shows the old row, new row starts unshifted
      load(3'd4, 8'd0, 4'b0010, 1'b0, 8'h80, 8'h80, 1'b0);
      strobe("ld_strobe_old", 4'b0101, 1'b0, 1'b0);
      strobe("ld_strobe_new", 4'b1011, 1'b0, 1'b0);
      strobe("ld_strobe_shift", 4'b0000, 1'b0, 1'b0);

      // render_en low clears outputs and freezes the slots
      load(3'd6, 8'd0, 4'b0001, 1'b0, 8'hFF, 8'h00, 1'b1);
      tick();
      release_load();
      strobe("ren_pre", 4'b0101, 1'b0, 1'b0);
      bus.render_en  = 1'b0;
      bus.next_pixel = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_outputs("ren_off", zero_e);
      end
      bus.next_pixel = 1'b0;
      bus.render_en  = 1'b1;
      for (int i = 0; i < 7; i++) strobe("ren_resume", 4'b0101, 1'b0, 1'b0);
      strobe("ren_end", 4'b0000, 1'b0, 1'b0);

      // rst mid-line, with a competing load that must be ignored
      load(3'd7, 8'd0, 4'b0111, 1'b1, 8'hFF, 8'h00, 1'b1);
      tick();
      release_load();
      strobe("pre_rst", 4'b1101, 1'b1, 1'b1);
      rst = 1'b1;
      load(3'd5, 8'd0, 4'b0011, 1'b0, 8'hFF, 8'hFF, 1'b0);
      tick();
      release_load();
      chk_outputs("mid_rst", zero_e);
      rst = 1'b0;
      strobe("post_rst", 4'b0000, 1'b0, 1'b0);

      // maximum X: 255 decrements before the first visible pixel
      load(3'd0, 8'hFF, 4'b0001, 1'b0, 8'hFF, 8'h00, 1'b1);
      tick();
      release_load();
      for (int i = 0; i < 255; i++) strobe("maxx_delay", 4'b0000, 1'b0, 1'b0);
      strobe("maxx_vis", 4'b0101, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
